// File: rtl/bf16_norm_pipe.sv
// ---------------------------------------------------------------------------
// bf16_norm_pipe -- normalisation stage for the BFloat16 datapath.
//
// Counts the leading zeros of an unnormalised mantissa, left-shifts it so the
// MSB is 1 and lowers the biased exponent by the same amount. Exact zeros and
// results whose exponent would reach or pass zero are flushed to zero and
// flagged. Two-stage valid/ready pipeline, bubble-collapsing, one beat per
// cycle, all outputs registered.
//
// Ports
//   clk      in   1    clock, all registers on posedge
//   nreset   in   1    asynchronous active-low reset
//   valid_i  in   1    input beat valid
//   ready_o  out  1    block can accept an input beat this cycle
//   sign_i   in   1    sign, passed through untouched
//   exp_i    in   E_W  biased exponent (unsigned)
//   man_i    in   M_W  unnormalised mantissa
//   valid_o  out  1    output beat valid
//   ready_i  in   1    downstream accepts the output beat this cycle
//   sign_o   out  1    sign
//   exp_o    out  E_W  adjusted exponent
//   man_o    out  M_W  normalised mantissa
//   zero_o   out  1    exact zero result
//   uf_o     out  1    underflow, result flushed to zero
//
// Also contains lzc: a tree leading-zero counter for a power-of-two width.
//   a_i    in   W     input vector
//   cnt_o  out  C_W   number of leading zeros (W when a_i is all zero)
// ---------------------------------------------------------------------------

module lzc #(
  parameter int W   = 16,
  parameter int C_W = $clog2(W + 1)
) (
  input  logic [W-1:0]   a_i,
  output logic [C_W-1:0] cnt_o
);

  localparam int L = $clog2(W);

  // Level l holds W>>l nodes, each covering 2**l input bits with an l-bit
  // count and an all-zero flag. A node's count comes from its upper child
  // unless that child is all zero, in which case the lower child's count is
  // used with the new MSB set (the upper half contributed 2**(l-1) zeros).
  for (genvar l = 1; l <= L; l++) begin : g_lvl
    localparam int N = W >> l;
    logic [N-1:0]   z;
    logic [N*l-1:0] c;
    for (genvar j = 0; j < N; j++) begin : g_node
      if (l == 1) begin : g_leaf
        assign z[j] = ~(a_i[2*j+1] | a_i[2*j]);
        assign c[j] = ~a_i[2*j+1];
      end else begin : g_merge
        localparam int P = l - 1;
        logic         z_hi;
        logic         z_lo;
        logic [P-1:0] c_hi;
        logic [P-1:0] c_lo;
        assign z_hi = g_lvl[l-1].z[2*j+1];
        assign z_lo = g_lvl[l-1].z[2*j];
        assign c_hi = g_lvl[l-1].c[(2*j+1)*P +: P];
        assign c_lo = g_lvl[l-1].c[(2*j)*P +: P];
        assign z[j] = z_hi & z_lo;
        assign c[j*l +: l] = z_hi ? {1'b1, c_lo} : {1'b0, c_hi};
      end
    end
  end

  // An all-zero input reports the full width rather than the tree's partial count.
  assign cnt_o = g_lvl[L].z[0] ? C_W'(W) : {1'b0, g_lvl[L].c};

endmodule

module bf16_norm_pipe #(
  parameter int M_W = 16,
  parameter int E_W = 8
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           valid_i,
  output logic           ready_o,
  input  logic           sign_i,
  input  logic [E_W-1:0] exp_i,
  input  logic [M_W-1:0] man_i,
  output logic           valid_o,
  input  logic           ready_i,
  output logic           sign_o,
  output logic [E_W-1:0] exp_o,
  output logic [M_W-1:0] man_o,
  output logic           zero_o,
  output logic           uf_o
);

  localparam int C_W = $clog2(M_W + 1);

  logic           s1_adv;
  logic           s2_adv;
  logic [C_W-1:0] lzc_cnt_s;

  logic           s1_valid_q;
  logic           s1_sign_q;
  logic [E_W-1:0] s1_exp_q;
  logic [M_W-1:0] s1_man_q;
  logic [C_W-1:0] s1_cnt_q;

  logic           s2_valid_q;
  logic           s2_sign_q;
  logic [E_W-1:0] s2_exp_q;
  logic [M_W-1:0] s2_man_q;
  logic           s2_zero_q;
  logic           s2_uf_q;

  logic           s2_sign_d;
  logic [E_W-1:0] s2_exp_d;
  logic [M_W-1:0] s2_man_d;
  logic           s2_zero_d;
  logic           s2_uf_d;
  logic [E_W-1:0] cnt_ext_s;

  // A stage may take new data when it is empty or its content moves on.
  assign s2_adv  = ~s2_valid_q | ready_i;
  assign s1_adv  = ~s1_valid_q | s2_adv;
  assign ready_o = s1_adv;

  lzc #(
    .W   (M_W),
    .C_W (C_W)
  ) u_lzc (
    .a_i   (man_i),
    .cnt_o (lzc_cnt_s)
  );

  // Stage 1 register: capture the beat together with its leading-zero count.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_man_q   <= '0;
      s1_cnt_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= valid_i;
      if (valid_i) begin
        s1_sign_q <= sign_i;
        s1_exp_q  <= exp_i;
        s1_man_q  <= man_i;
        s1_cnt_q  <= lzc_cnt_s;
      end
    end
  end

  assign cnt_ext_s = E_W'(s1_cnt_q);

  // Stage 2 next state: zero / underflow flush or shift-and-adjust.
  // The compare guarantees exp - cnt never wraps in the normal path.
  always_comb begin
    s2_sign_d = s1_sign_q;
    s2_exp_d  = '0;
    s2_man_d  = '0;
    s2_zero_d = 1'b0;
    s2_uf_d   = 1'b0;
    if (s1_man_q == {M_W{1'b0}}) begin
      s2_zero_d = 1'b1;
    end else if (cnt_ext_s >= s1_exp_q) begin
      s2_uf_d = 1'b1;
    end else begin
      s2_exp_d = s1_exp_q - cnt_ext_s;
      s2_man_d = s1_man_q << s1_cnt_q;
    end
  end

  // Stage 2 register: holds the output beat stable while downstream stalls.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_man_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_uf_q    <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s2_sign_d;
      s2_exp_q   <= s2_exp_d;
      s2_man_q   <= s2_man_d;
      s2_zero_q  <= s2_zero_d;
      s2_uf_q    <= s2_uf_d;
    end
  end

  assign valid_o = s2_valid_q;
  assign sign_o  = s2_sign_q;
  assign exp_o   = s2_exp_q;
  assign man_o   = s2_man_q;
  assign zero_o  = s2_zero_q;
  assign uf_o    = s2_uf_q;

endmodule

// File: tb/tb_bf16_norm_pipe.sv
// ---------------------------------------------------------------------------
// Testbench for bf16_norm_pipe (M_W=16, E_W=8): directed vectors, a stalled
// back-to-back stream, a random stream against a shift/compare model, and a
// mid-operation asynchronous reset.
// ---------------------------------------------------------------------------

module tb_bf16_norm_pipe;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [15:0] man;
    logic        zero;
    logic        uf;
  } res_t;

  logic        clk;
  logic        nreset;
  logic        valid_i;
  logic        ready_o;
  logic        sign_i;
  logic [7:0]  exp_i;
  logic [15:0] man_i;
  logic        valid_o;
  logic        ready_i;
  logic        sign_o;
  logic [7:0]  exp_o;
  logic [15:0] man_o;
  logic        zero_o;
  logic        uf_o;

  int checks;
  int failures;

  bf16_norm_pipe #(.M_W(16), .E_W(8)) dut (
    .clk     (clk),
    .nreset  (nreset),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .sign_i  (sign_i),
    .exp_i   (exp_i),
    .man_i   (man_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sign_o  (sign_o),
    .exp_o   (exp_o),
    .man_o   (man_o),
    .zero_o  (zero_o),
    .uf_o    (uf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: scan for the highest set bit, then compare and shift.
  function automatic res_t ref_model(input logic s, input logic [7:0] e, input logic [15:0] m);
    res_t r;
    int   cnt;
    cnt = 16;
    for (int i = 0; i < 16; i++) if (m[i]) cnt = 15 - i;
    r.sign = s;
    r.exp  = 8'd0;
    r.man  = 16'd0;
    r.zero = 1'b0;
    r.uf   = 1'b0;
    if (m == 16'd0) r.zero = 1'b1;
    else if (cnt >= int'(e)) r.uf = 1'b1;
    else begin
      r.exp = e - 8'(cnt);
      r.man = m << cnt;
    end
    return r;
  endfunction

  function automatic res_t observed();
    return {sign_o, exp_o, man_o, zero_o, uf_o};
  endfunction

  // Presents one beat for one cycle into an empty pipeline; returns at the
  // following negedge with the beat sitting in stage 1.
  task automatic drive_single(input logic s, input logic [7:0] e, input logic [15:0] m);
    @(negedge clk);
    valid_i = 1'b1;
    sign_i  = s;
    exp_i   = e;
    man_i   = m;
    ready_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic test_reset;
    nreset  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    sign_i  = 1'b0;
    exp_i   = 8'd0;
    man_i   = 16'd0;
    #12;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_hs got valid_o=%b ready_o=%b exp valid_o=0 ready_o=1", valid_o, ready_o);
    end
    checks++;
    if (observed() !== res_t'(27'd0)) begin
      failures++;
      $display("FAIL reset_data got=%h exp=%h", observed(), res_t'(27'd0));
    end
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic test_normalise;
    res_t expv;
    expv = '{sign: 1'b1, exp: 8'd123, man: 16'h8000, zero: 1'b0, uf: 1'b0};
    drive_single(1'b1, 8'd130, 16'h0100);
    checks++;
    if (valid_o !== 1'b0) begin
      failures++;
      $display("FAIL norm_latency got valid_o=%b exp 0 one cycle after accept", valid_o);
    end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b1) begin
      failures++;
      $display("FAIL norm_valid got valid_o=%b exp 1", valid_o);
    end
    checks++;
    if (observed() !== expv) begin
      failures++;
      $display("FAIL norm_data got=%h exp=%h", observed(), expv);
    end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0) begin
      failures++;
      $display("FAIL norm_single got valid_o=%b exp 0 (beat duplicated)", valid_o);
    end
  endtask

  task automatic test_zero;
    res_t expv;
    expv = '{sign: 1'b1, exp: 8'd0, man: 16'h0000, zero: 1'b1, uf: 1'b0};
    drive_single(1'b1, 8'd77, 16'h0000);
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b1 || observed() !== expv) begin
      failures++;
      $display("FAIL zero got valid=%b data=%h exp valid=1 data=%h", valid_o, observed(), expv);
    end
  endtask

  task automatic test_underflow;
    logic [7:0]  e_tab [3];
    logic [15:0] m_tab [3];
    res_t        x_tab [3];
    e_tab[0] = 8'd10; m_tab[0] = 16'h0001;
    x_tab[0] = '{sign: 1'b0, exp: 8'd0, man: 16'h0000, zero: 1'b0, uf: 1'b1};
    e_tab[1] = 8'd1;  m_tab[1] = 16'h8000;
    x_tab[1] = '{sign: 1'b0, exp: 8'd1, man: 16'h8000, zero: 1'b0, uf: 1'b0};
    e_tab[2] = 8'd0;  m_tab[2] = 16'h8000;
    x_tab[2] = '{sign: 1'b0, exp: 8'd0, man: 16'h0000, zero: 1'b0, uf: 1'b1};
    for (int k = 0; k < 3; k++) begin
      drive_single(1'b0, e_tab[k], m_tab[k]);
      @(negedge clk);
      checks++;
      if (valid_o !== 1'b1 || observed() !== x_tab[k]) begin
        failures++;
        $display("FAIL uf_case%0d got valid=%b data=%h exp valid=1 data=%h",
                 k, valid_o, observed(), x_tab[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    res_t q[$];
    res_t prev;
    res_t cur;
    res_t expv;
    logic prev_stall;
    int   sent;
    int   got;
    int   occ;
    int   low_seen;
    sent = 0; got = 0; occ = 0; low_seen = 0; prev_stall = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(negedge clk);
      valid_i = (sent < 8);
      sign_i  = sent[0];
      exp_i   = 8'(100 + sent);
      man_i   = 16'h4000 >> sent;
      ready_i = !(cyc >= 3 && cyc <= 5);
      #1;
      cur = observed();
      checks++;
      if (ready_o !== ((occ < 2) || ready_i)) begin
        failures++;
        $display("FAIL b2b_ready cyc%0d got=%b exp=%b", cyc, ready_o, ((occ < 2) || ready_i));
      end
      if (ready_o === 1'b0) low_seen++;
      if (prev_stall) begin
        checks++;
        if (valid_o !== 1'b1 || cur !== prev) begin
          failures++;
          $display("FAIL b2b_stable cyc%0d got valid=%b data=%h exp valid=1 data=%h", cyc, valid_o, cur, prev);
        end
      end
      if (valid_o === 1'b1 && ready_i) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra got=%h exp no beat", cur);
        end else begin
          expv = q.pop_front();
          if (cur !== expv) begin
            failures++;
            $display("FAIL b2b_data beat%0d got=%h exp=%h", got, cur, expv);
          end
        end
        got++;
        occ--;
      end
      if (valid_i && ready_o === 1'b1) begin
        q.push_back(ref_model(sign_i, exp_i, man_i));
        sent++;
        occ++;
      end
      prev_stall = (valid_o === 1'b1) && !ready_i;
      prev = cur;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    checks++;
    if (sent != 8 || got != 8) begin
      failures++;
      $display("FAIL b2b_count got sent=%0d emitted=%0d exp 8/8", sent, got);
    end
    checks++;
    if (low_seen == 0) begin
      failures++;
      $display("FAIL b2b_backpressure got ready_o low cycles=0 exp >=1");
    end
  endtask

  task automatic test_random;
    localparam int NBEATS = 10000;
    localparam int BOUND  = 40000;
    res_t q[$];
    res_t cur;
    res_t prev;
    res_t expv;
    logic prev_stall;
    int   sent;
    int   got;
    int   occ;
    int   errs;
    int   cyc;
    sent = 0; got = 0; occ = 0; errs = 0; cyc = 0; prev_stall = 1'b0; prev = '0;
    while (got < NBEATS && cyc < BOUND) begin
      @(negedge clk);
      valid_i = (sent < NBEATS) && ($urandom_range(0, 9) < 7);
      sign_i  = 1'($urandom);
      exp_i   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom);
      man_i   = 16'($urandom) >> $urandom_range(0, 16);
      ready_i = ($urandom_range(0, 9) < 7);
      #1;
      cur = observed();
      checks++;
      if (ready_o !== ((occ < 2) || ready_i)) begin
        failures++;
        errs++;
        if (errs < 10) $display("FAIL rnd_ready cyc%0d got=%b exp=%b", cyc, ready_o, ((occ < 2) || ready_i));
      end
      if (prev_stall) begin
        checks++;
        if (valid_o !== 1'b1 || cur !== prev) begin
          failures++;
          errs++;
          if (errs < 10) $display("FAIL rnd_stable cyc%0d got=%h exp=%h", cyc, cur, prev);
        end
      end
      if (valid_o === 1'b1 && ready_i) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          errs++;
          if (errs < 10) $display("FAIL rnd_extra got=%h exp no beat", cur);
        end else begin
          expv = q.pop_front();
          if (cur !== expv) begin
            failures++;
            errs++;
            if (errs < 10) $display("FAIL rnd_data beat%0d got=%h exp=%h", got, cur, expv);
          end
        end
        got++;
        occ--;
      end
      if (valid_i && ready_o === 1'b1) begin
        q.push_back(ref_model(sign_i, exp_i, man_i));
        sent++;
        occ++;
      end
      prev_stall = (valid_o === 1'b1) && !ready_i;
      prev = cur;
      cyc++;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    checks++;
    if (sent != NBEATS || got != NBEATS || q.size() != 0) begin
      failures++;
      $display("FAIL rnd_count got in=%0d out=%0d pending=%0d exp %0d/%0d/0", sent, got, q.size(), NBEATS, NBEATS);
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    @(negedge clk);
    ready_i = 1'b0;
    valid_i = 1'b1;
    sign_i  = 1'b1;
    exp_i   = 8'd50;
    man_i   = 16'h0F00;
    @(negedge clk);
    exp_i   = 8'd60;
    man_i   = 16'h00F0;
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b1 || ready_o !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_full got valid_o=%b ready_o=%b exp 1/0", valid_o, ready_o);
    end
    #2;
    nreset = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || observed() !== res_t'(27'd0)) begin
      failures++;
      $display("FAIL rstmid_async got valid_o=%b ready_o=%b data=%h exp 0/1/0", valid_o, ready_o, observed());
    end
    @(negedge clk);
    nreset  = 1'b1;
    ready_i = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (valid_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rstmid_stale got valid_o high cycles=%0d exp 0", bad);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_normalise();
    test_zero();
    test_underflow();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
